// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state encoding and geometry helpers for the cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        CC_FLUSH   = 3'd0,
        CC_IDLE    = 3'd1,
        CC_LOOKUP  = 3'd2,
        CC_MEMREQ  = 3'd3,
        CC_MEMWAIT = 3'd4,
        CC_RESP    = 3'd5
    } cc_state_e;

    // Number of lines in a direct-mapped array indexed by indexw bits.
    function automatic int num_lines(input int indexw);
        return 1 << indexw;
    endfunction

    // Tag bits left over once the index is taken from a word address.
    function automatic int tag_width(input int aw, input int indexw);
        return aw - indexw;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU request/response and memory request/response bundle.
// master = CPU plus memory side (the environment), slave = the cache controller.
interface cache_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_write;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_resp_valid;
    logic [DW-1:0] cpu_resp_rdata;
    logic          cpu_resp_hit;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/cache_ctrl_array.sv
// cache_ctrl_array: data/tag storage with a 1-cycle synchronous read, one write
// port, and per-line valid bits kept in flops so the FLUSH walk can clear them.
module cache_ctrl_array
    import cache_pkg::*;
#(
    parameter int DW     = 32,
    parameter int INDEXW = 6,
    parameter int TW     = 4
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [INDEXW-1:0] rd_idx_i,
    output logic [DW-1:0]     rd_data_o,
    output logic [TW-1:0]     rd_tag_o,
    output logic              rd_valid_o,
    input  logic              wr_en_i,
    input  logic [INDEXW-1:0] wr_idx_i,
    input  logic [TW-1:0]     wr_tag_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              clr_en_i,
    input  logic [INDEXW-1:0] clr_idx_i
);
    localparam int NUM_LINES = num_lines(INDEXW);

    logic [DW-1:0]        data_mem [NUM_LINES];
    logic [TW-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [DW-1:0]        rd_data_q;
    logic [TW-1:0]        rd_tag_q;
    logic                 rd_valid_q;

    // Line write on refill/allocate, registered read for lookup.
    // NOTE: data/tag storage has no reset; a line is only trusted once its valid
    // bit is set, and the post-reset FLUSH walk clears every valid bit first.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_mem[wr_idx_i] <= wr_data_i;
            tag_mem[wr_idx_i]  <= wr_tag_i;
        end
        if (rd_en_i) begin
            rd_data_q  <= data_mem[rd_idx_i];
            rd_tag_q   <= tag_mem[rd_idx_i];
            rd_valid_q <= valid_q[rd_idx_i];
        end
    end

    // Valid bits: cleared by the FLUSH walk, set by any line write.
    always_ff @(posedge clk) begin
        if (clr_en_i) begin
            valid_q[clr_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing FSM for a direct-mapped, one-word-per-line, write-through
// cache. Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN
// is defined.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int INDEXW = 6,
    parameter int CW     = 32
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.slave  bus,
    input  logic         flush,
    output logic         flush_done
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [CW-1:0] stat_hits,
    output logic [CW-1:0] stat_misses
`endif
);
    localparam int NUM_LINES = num_lines(INDEXW);
    localparam int TW        = tag_width(AW, INDEXW);
    localparam logic [INDEXW:0] LAST_FIDX = (INDEXW + 1)'(NUM_LINES - 1);

    cc_state_e       state_q, state_d;
    logic [INDEXW:0] fidx_q, fidx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            write_q, write_d;
    logic            hit_q, hit_d;

    logic            arr_rd_en;
    logic [DW-1:0]   arr_rd_data;
    logic [TW-1:0]   arr_rd_tag;
    logic            arr_rd_valid;
    logic            arr_wr_en;
    logic [DW-1:0]   arr_wr_data;
    logic            arr_clr_en;
    logic            lookup_hit;

    cache_ctrl_array #(
        .DW     (DW),
        .INDEXW (INDEXW),
        .TW     (TW)
    ) u_array (
        .clk        (clk),
        .rd_en_i    (arr_rd_en),
        .rd_idx_i   (bus.cpu_req_addr[INDEXW-1:0]),
        .rd_data_o  (arr_rd_data),
        .rd_tag_o   (arr_rd_tag),
        .rd_valid_o (arr_rd_valid),
        .wr_en_i    (arr_wr_en),
        .wr_idx_i   (addr_q[INDEXW-1:0]),
        .wr_tag_i   (addr_q[AW-1:INDEXW]),
        .wr_data_i  (arr_wr_data),
        .clr_en_i   (arr_clr_en),
        .clr_idx_i  (fidx_q[INDEXW-1:0])
    );

    assign lookup_hit = arr_rd_valid && (arr_rd_tag == addr_q[AW-1:INDEXW]);

    // State and request registers; reset aborts any in-flight operation.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CC_FLUSH;
            fidx_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state, array control and bus outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d             = state_q;
        fidx_d              = fidx_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        rdata_d             = rdata_q;
        write_d             = write_q;
        hit_d               = hit_q;
        arr_rd_en           = 1'b0;
        arr_wr_en           = 1'b0;
        arr_wr_data         = wdata_q;
        arr_clr_en          = 1'b0;
        flush_done          = 1'b0;
        bus.cpu_req_ready   = 1'b0;
        bus.cpu_resp_valid  = 1'b0;
        bus.cpu_resp_rdata  = '0;
        bus.cpu_resp_hit    = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_write   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_wdata   = '0;

        unique case (state_q)
            CC_FLUSH: begin
                arr_clr_en = 1'b1;
                if (fidx_q == LAST_FIDX) begin
                    flush_done = 1'b1;
                    fidx_d     = '0;
                    state_d    = CC_IDLE;
                end else begin
                    fidx_d = fidx_q + 1'b1;
                end
            end
            CC_IDLE: begin
                bus.cpu_req_ready = !flush;
                if (flush) begin
                    fidx_d  = '0;
                    state_d = CC_FLUSH;
                end else if (bus.cpu_req_valid) begin
                    addr_d    = bus.cpu_req_addr;
                    wdata_d   = bus.cpu_req_wdata;
                    write_d   = bus.cpu_req_write;
                    arr_rd_en = 1'b1;
                    state_d   = CC_LOOKUP;
                end
            end
            CC_LOOKUP: begin
                hit_d = lookup_hit;
                if (!write_q && lookup_hit) begin
                    rdata_d = arr_rd_data;
                    state_d = CC_RESP;
                end else begin
                    rdata_d = '0;
                    state_d = CC_MEMREQ;
                end
            end
            CC_MEMREQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = write_q;
                bus.mem_req_addr  = addr_q;
                bus.mem_req_wdata = wdata_q;
                if (bus.mem_req_ready) begin
                    state_d = CC_MEMWAIT;
                end
            end
            CC_MEMWAIT: begin
                if (bus.mem_resp_valid) begin
                    // Writes allocate with their own data; reads refill from memory.
                    arr_wr_en   = 1'b1;
                    arr_wr_data = write_q ? wdata_q : bus.mem_resp_rdata;
                    rdata_d     = write_q ? '0 : bus.mem_resp_rdata;
                    state_d     = CC_RESP;
                end
            end
            CC_RESP: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_resp_rdata = rdata_q;
                bus.cpu_resp_hit   = hit_q;
                state_d            = CC_IDLE;
            end
            default: begin
                state_d = CC_FLUSH;
                fidx_d  = '0;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [CW-1:0] stat_hits_q;
    logic [CW-1:0] stat_misses_q;

    // Saturating hit/miss counters; one of them steps per response, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (state_q == CC_RESP) begin
            if (hit_q) begin
                if (stat_hits_q != '1) stat_hits_q <= stat_hits_q + 1'b1;
            end else begin
                if (stat_misses_q != '1) stat_misses_q <= stat_misses_q + 1'b1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule
